// File: rtl/alu_mul_sequencer_if.sv
// Handshake/data bundle between the EX stage and the multi-cycle multiply
// sequencer. The pipeline side (master) presents the decoded instruction and
// operands; the sequencer side (slave) answers with stall, busy, done and the
// product.
interface alu_mul_sequencer_if #(
  parameter int WIDTH = 32
);
  logic             start_i;
  logic [2:0]       alu_ctrl_i;
  logic [WIDTH-1:0] data1_i;
  logic [WIDTH-1:0] data2_i;
  logic             flush_i;
  logic             stall_o;
  logic             busy_o;
  logic             done_o;
  logic [WIDTH-1:0] result_o;

  modport master (
    output start_i, alu_ctrl_i, data1_i, data2_i, flush_i,
    input  stall_o, busy_o, done_o, result_o
  );

  modport slave (
    input  start_i, alu_ctrl_i, data1_i, data2_i, flush_i,
    output stall_o, busy_o, done_o, result_o
  );
endinterface

// File: rtl/alu_mul_sequencer.sv
// Multi-cycle shift-add multiplier sitting beside the EX-stage ALU. It claims
// the MUL control code, stalls the front of the pipeline for WIDTH+1 cycles,
// and presents the low WIDTH bits of the product with a one-cycle done pulse.
module alu_mul_sequencer #(
  parameter int         WIDTH    = 32,
  parameter logic [2:0] MUL_CODE = 3'b100
) (
  input logic                clk_i,
  input logic                rst_i,
  alu_mul_sequencer_if.slave bus
);

  localparam int CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state;
  state_t           next_state;
  logic [WIDTH-1:0] mcand;
  logic [WIDTH-1:0] mplier;
  logic [WIDTH-1:0] acc;
  logic [CNT_W-1:0] cnt;
  logic [WIDTH-1:0] result_q;
  logic             accept;
  logic             last_iter;
  logic [WIDTH-1:0] acc_sum;

  // A MUL is only taken from IDLE; a flush in the same cycle vetoes it so a
  // squashed instruction never starts.
  assign accept    = (state == IDLE) && bus.start_i &&
                     (bus.alu_ctrl_i == MUL_CODE) && !bus.flush_i;
  assign last_iter = (cnt == LAST_CNT);
  assign acc_sum   = mplier[0] ? (acc + mcand) : acc;

  // Stall covers the accepting IDLE cycle and every RUN cycle; it is low in
  // DONE so the pipeline advances on the edge that leaves DONE.
  assign bus.stall_o  = accept || (state == RUN);
  assign bus.busy_o   = (state == RUN);
  assign bus.done_o   = (state == DONE);
  assign bus.result_o = result_q;

  // State register.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state decode; flush wins over everything and DONE never restarts
  // even though the stalled MUL is still sitting on the inputs.
  always_comb begin
    next_state = state;
    if (bus.flush_i) begin
      next_state = IDLE;
    end else begin
      case (state)
        IDLE:    if (accept) next_state = RUN;
        RUN:     if (last_iter) next_state = DONE;
        DONE:    next_state = IDLE;
        default: next_state = IDLE;
      endcase
    end
  end

  // Shift-add datapath: one multiplier bit per RUN cycle, product captured
  // into result_q on the final iteration including that cycle's add.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      mcand    <= '0;
      mplier   <= '0;
      acc      <= '0;
      cnt      <= '0;
      result_q <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            mcand  <= bus.data1_i;
            mplier <= bus.data2_i;
            acc    <= '0;
            cnt    <= '0;
          end
        end
        RUN: begin
          if (bus.flush_i) begin
            cnt <= '0;
          end else begin
            acc    <= acc_sum;
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
            cnt    <= cnt + 1'b1;
            if (last_iter) begin
              result_q <= acc_sum;
            end
          end
        end
        default: begin
          cnt <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_mul_sequencer.sv
// Directed bench for alu_mul_sequencer: each scenario task drives the bus and
// compares outputs against hand-computed values, sampling 1ns after the
// falling clock edge.
module tb_alu_mul_sequencer;

  localparam logic [2:0] MUL = 3'b100;

  logic clk_i;
  logic rst_i;
  int   checks;
  int   failures;

  alu_mul_sequencer_if #(.WIDTH(32)) bus ();

  alu_mul_sequencer #(.WIDTH(32), .MUL_CODE(3'b100)) dut (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .bus   (bus.slave)
  );

  // 10ns clock.
  initial begin
    clk_i = 1'b0;
    forever #5 clk_i = ~clk_i;
  end

  // Presents a MUL starting at the next falling edge and holds it until the
  // done pulse is seen, reporting stalled cycles, done latency and product.
  // lat stays -1 if no done arrives within the cycle budget.
  task automatic run_mul(input logic [31:0] a, input logic [31:0] b,
                         output int stalls, output int lat,
                         output logic [31:0] res);
    @(negedge clk_i);
    bus.start_i    = 1'b1;
    bus.alu_ctrl_i = MUL;
    bus.data1_i    = a;
    bus.data2_i    = b;
    #1;
    stalls = 0;
    lat    = -1;
    res    = 32'hDEAD_BEEF;
    for (int i = 0; i < 80; i++) begin
      if (bus.stall_o === 1'b1) stalls++;
      if (bus.done_o === 1'b1) begin
        lat = i;
        res = bus.result_o;
        break;
      end
      @(negedge clk_i);
      #1;
    end
  endtask

  task automatic test_reset();
    rst_i = 1'b1;
    #12;
    checks++; if (bus.stall_o !== 1'b0) begin failures++; $display("[TB] FAIL reset_stall got=%0b exp=0", bus.stall_o); end
    checks++; if (bus.busy_o !== 1'b0) begin failures++; $display("[TB] FAIL reset_busy got=%0b exp=0", bus.busy_o); end
    checks++; if (bus.done_o !== 1'b0) begin failures++; $display("[TB] FAIL reset_done got=%0b exp=0", bus.done_o); end
    checks++; if (bus.result_o !== 32'h0) begin failures++; $display("[TB] FAIL reset_result got=%h exp=0", bus.result_o); end
    @(negedge clk_i);
    rst_i = 1'b0;
  endtask

  task automatic test_wrap();
    int stalls, lat;
    logic [31:0] res;
    run_mul(32'hFFFF_FFFF, 32'hFFFF_FFFF, stalls, lat, res);
    checks++; if (lat !== 33) begin failures++; $display("[TB] FAIL wrap1_latency got=%0d exp=33", lat); end
    checks++; if (res !== 32'h0000_0001) begin failures++; $display("[TB] FAIL wrap1_result got=%h exp=00000001", res); end
    run_mul(32'h8000_0000, 32'h0000_0002, stalls, lat, res);
    checks++; if (lat !== 33) begin failures++; $display("[TB] FAIL wrap2_latency got=%0d exp=33", lat); end
    checks++; if (res !== 32'h0) begin failures++; $display("[TB] FAIL wrap2_result got=%h exp=00000000", res); end
    @(negedge clk_i);
    bus.start_i = 1'b0;
  endtask

  task automatic test_basic();
    int stalls, lat;
    logic [31:0] res;
    run_mul(32'd3, 32'd5, stalls, lat, res);
    checks++; if (stalls !== 33) begin failures++; $display("[TB] FAIL basic_stall_cycles got=%0d exp=33", stalls); end
    checks++; if (lat !== 33) begin failures++; $display("[TB] FAIL basic_latency got=%0d exp=33", lat); end
    checks++; if (res !== 32'd15) begin failures++; $display("[TB] FAIL basic_result got=%0d exp=15", res); end
    checks++; if (bus.stall_o !== 1'b0) begin failures++; $display("[TB] FAIL basic_stall_in_done got=%0b exp=0", bus.stall_o); end
    @(negedge clk_i);
    bus.start_i = 1'b0;
    #1;
    checks++; if (bus.busy_o !== 1'b0) begin failures++; $display("[TB] FAIL basic_no_restart got=%0b exp=0", bus.busy_o); end
    checks++; if (bus.done_o !== 1'b0) begin failures++; $display("[TB] FAIL basic_single_done got=%0b exp=0", bus.done_o); end
  endtask

  task automatic test_passthrough();
    logic [2:0] codes [2];
    codes[0] = 3'b000;
    codes[1] = 3'b110;
    for (int c = 0; c < 2; c++) begin
      for (int k = 0; k < 5; k++) begin
        @(negedge clk_i);
        bus.start_i    = 1'b1;
        bus.alu_ctrl_i = codes[c];
        bus.data1_i    = 32'd9;
        bus.data2_i    = 32'd9;
        #1;
        checks++; if (bus.stall_o !== 1'b0) begin failures++; $display("[TB] FAIL pass_stall code=%b got=%0b exp=0", codes[c], bus.stall_o); end
        checks++; if (bus.busy_o !== 1'b0) begin failures++; $display("[TB] FAIL pass_busy code=%b got=%0b exp=0", codes[c], bus.busy_o); end
        checks++; if (bus.done_o !== 1'b0) begin failures++; $display("[TB] FAIL pass_done code=%b got=%0b exp=0", codes[c], bus.done_o); end
      end
    end
    @(negedge clk_i);
    bus.start_i = 1'b0;
    #1;
    checks++; if (bus.busy_o !== 1'b0) begin failures++; $display("[TB] FAIL pass_stayed_idle got=%0b exp=0", bus.busy_o); end
  endtask

  task automatic test_flush();
    int stalls, lat, dones;
    logic [31:0] res;
    @(negedge clk_i);
    bus.start_i    = 1'b1;
    bus.alu_ctrl_i = MUL;
    bus.data1_i    = 32'd7;
    bus.data2_i    = 32'd9;
    for (int k = 0; k < 10; k++) @(negedge clk_i);
    #1;
    checks++; if (bus.busy_o !== 1'b1) begin failures++; $display("[TB] FAIL flush_running got=%0b exp=1", bus.busy_o); end
    bus.flush_i = 1'b1;
    bus.start_i = 1'b0;
    @(negedge clk_i);
    bus.flush_i = 1'b0;
    #1;
    checks++; if (bus.busy_o !== 1'b0) begin failures++; $display("[TB] FAIL flush_busy got=%0b exp=0", bus.busy_o); end
    checks++; if (bus.stall_o !== 1'b0) begin failures++; $display("[TB] FAIL flush_stall got=%0b exp=0", bus.stall_o); end
    // flush together with a MUL start in IDLE: flush must win
    @(negedge clk_i);
    bus.start_i = 1'b1;
    bus.flush_i = 1'b1;
    #1;
    checks++; if (bus.stall_o !== 1'b0) begin failures++; $display("[TB] FAIL flush_priority_stall got=%0b exp=0", bus.stall_o); end
    @(negedge clk_i);
    bus.start_i = 1'b0;
    bus.flush_i = 1'b0;
    #1;
    checks++; if (bus.busy_o !== 1'b0) begin failures++; $display("[TB] FAIL flush_priority_busy got=%0b exp=0", bus.busy_o); end
    dones = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk_i);
      #1;
      if (bus.done_o === 1'b1) dones++;
    end
    checks++; if (dones !== 0) begin failures++; $display("[TB] FAIL flush_no_done got=%0d exp=0", dones); end
    checks++; if (bus.result_o !== 32'd15) begin failures++; $display("[TB] FAIL flush_result_kept got=%0d exp=15", bus.result_o); end
    run_mul(32'd2, 32'd4, stalls, lat, res);
    checks++; if (lat !== 33) begin failures++; $display("[TB] FAIL flush_next_latency got=%0d exp=33", lat); end
    checks++; if (res !== 32'd8) begin failures++; $display("[TB] FAIL flush_next_result got=%0d exp=8", res); end
    @(negedge clk_i);
    bus.start_i = 1'b0;
  endtask

  task automatic test_async_reset();
    int stalls, lat;
    logic [31:0] res;
    @(negedge clk_i);
    bus.start_i    = 1'b1;
    bus.alu_ctrl_i = MUL;
    bus.data1_i    = 32'd11;
    bus.data2_i    = 32'd13;
    for (int k = 0; k < 20; k++) @(negedge clk_i);
    #1;
    checks++; if (bus.busy_o !== 1'b1) begin failures++; $display("[TB] FAIL areset_running got=%0b exp=1", bus.busy_o); end
    #1;
    rst_i       = 1'b1;
    bus.start_i = 1'b0;
    #1;
    checks++; if (bus.stall_o !== 1'b0) begin failures++; $display("[TB] FAIL areset_stall got=%0b exp=0", bus.stall_o); end
    checks++; if (bus.busy_o !== 1'b0) begin failures++; $display("[TB] FAIL areset_busy got=%0b exp=0", bus.busy_o); end
    checks++; if (bus.result_o !== 32'h0) begin failures++; $display("[TB] FAIL areset_result got=%h exp=0", bus.result_o); end
    @(negedge clk_i);
    rst_i = 1'b0;
    run_mul(32'd6, 32'd7, stalls, lat, res);
    checks++; if (lat !== 33) begin failures++; $display("[TB] FAIL areset_next_latency got=%0d exp=33", lat); end
    checks++; if (res !== 32'd42) begin failures++; $display("[TB] FAIL areset_next_result got=%0d exp=42", res); end
    @(negedge clk_i);
    bus.start_i = 1'b0;
  endtask

  task automatic test_back_to_back();
    int stalls, lat1, lat2, dones;
    logic [31:0] res1, res2;
    run_mul(32'd10, 32'd10, stalls, lat1, res1);
    run_mul(32'h1234_5678, 32'h0000_0010, stalls, lat2, res2);
    checks++; if (lat1 !== 33) begin failures++; $display("[TB] FAIL b2b_first_latency got=%0d exp=33", lat1); end
    checks++; if (res1 !== 32'd100) begin failures++; $display("[TB] FAIL b2b_first_result got=%0d exp=100", res1); end
    checks++; if (lat2 + 1 !== 34) begin failures++; $display("[TB] FAIL b2b_done_spacing got=%0d exp=34", lat2 + 1); end
    checks++; if (stalls !== 33) begin failures++; $display("[TB] FAIL b2b_second_stalls got=%0d exp=33", stalls); end
    checks++; if (res2 !== 32'h2345_6780) begin failures++; $display("[TB] FAIL b2b_second_result got=%h exp=23456780", res2); end
    @(negedge clk_i);
    bus.start_i = 1'b0;
    dones = 0;
    for (int k = 0; k < 40; k++) begin
      #1;
      if (bus.done_o === 1'b1) dones++;
      @(negedge clk_i);
    end
    checks++; if (dones !== 0) begin failures++; $display("[TB] FAIL b2b_extra_done got=%0d exp=0", dones); end
  endtask

  // Scenario sequence.
  initial begin
    checks         = 0;
    failures       = 0;
    rst_i          = 1'b1;
    bus.start_i    = 1'b0;
    bus.alu_ctrl_i = 3'b000;
    bus.data1_i    = '0;
    bus.data2_i    = '0;
    bus.flush_i    = 1'b0;
    test_reset();
    test_wrap();
    test_basic();
    test_passthrough();
    test_flush();
    test_async_reset();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/alu_mul_sequencer.md
# alu_mul_sequencer

Multi-cycle multiply sequencer beside the EX-stage ALU. When the ALU control decode presents the MUL code, this block takes over the operation. It runs a 32-iteration shift-add multiply, holds the pipeline with a stall until the product is ready, then releases the stall with the result valid. All other ALU control codes pass through untouched and are handled by the single-cycle ALU.

## Interface
- WIDTH, 32, operand/result width; iteration count equals WIDTH
- MUL_CODE, 3'b100, ALU control code that selects this block
- clk_i  input  1  clock, rising-edge
- rst_i  input  1  reset, asynchronous, active-high
- start_i  input  1  EX stage holds a valid instruction this cycle
- alu_ctrl_i  input  3  ALU control code from ALU control decode
- data1_i  input  WIDTH  multiplicand (rs1 value)
- data2_i  input  WIDTH  multiplier (rs2 value)
- flush_i  input  1  abort current operation (pipeline flush)
- stall_o  output  1  hold PC/IF/ID/ID-EX registers
- busy_o  output  1  state is RUN
- done_o  output  1  one-cycle pulse: result_o valid
- result_o  output  WIDTH  low WIDTH bits of product

## Operation
- States: IDLE, RUN, DONE. Registers: state, mcand (WIDTH), mplier (WIDTH), acc (WIDTH), cnt (log2(WIDTH) bits), result_o.
- IDLE:
  - If start_i && alu_ctrl_i==MUL_CODE && !flush_i: latch mcand=data1_i, mplier=data2_i, acc=0, cnt=0; next state RUN.
  - Otherwise stay in IDLE.
- RUN, each cycle:
  - If mplier[0]: acc = acc + mcand, truncated to WIDTH.
  - mcand <<= 1 (logical); mplier >>= 1 (logical); cnt++.
  - When cnt==WIDTH-1: write final acc (including this cycle's add) to result_o; next state DONE.
- DONE: done_o=1; next state IDLE unconditionally. start_i is ignored in DONE: the stalled MUL is still present on the inputs and must not restart.
- Arithmetic: result_o = (data1_i*data2_i) mod 2^WIDTH. Signed and unsigned give identical low bits, so there is no sign handling.
- stall_o is combinational: (IDLE && start_i && alu_ctrl_i==MUL_CODE && !flush_i) || RUN. It is 0 in DONE, so the pipeline advances on the DONE edge.
- busy_o = (state==RUN), registered state decode.
- result_o holds its last value until the next DONE. A flush does not modify result_o.
- flush_i, any state: next state IDLE, no done_o, cnt cleared. flush_i has priority over start_i.
- Non-MUL codes with start_i=1: no state change, stall_o=0.

## Timing
- Reset (async assert, any state): state=IDLE, stall_o=0, busy_o=0, done_o=0, result_o=0, acc=0, cnt=0, mcand=0, mplier=0.
- Release of reset is synchronous to clk_i; the first evaluation happens at the first rising edge after deassert.
- Cycle 0: IDLE with MUL start; stall_o=1 combinationally.
- Cycles 1..WIDTH: RUN; stall_o=1, busy_o=1.
- Cycle WIDTH+1: DONE; done_o=1, result_o valid, stall_o=0.
- Total stall: WIDTH+1 cycles (33 at default). Start-to-done latency: WIDTH+1 cycles.
- Back-to-back MULs: the second MUL arrives at cycle WIDTH+2 (IDLE) and starts with no bubble beyond the DONE cycle.
- Flush during cycle k of RUN: the next edge goes to IDLE and stall_o drops in that cycle. A new start can be accepted the cycle after.
- Reset mid-RUN: all outputs go to reset values immediately; the operation is discarded.

## Test plan
- Basic multiply: reset, then start with MUL, data1=3, data2=5.
  - stall_o high for exactly 33 cycles.
  - done_o pulses at cycle 33; result_o=15.
- Wrap-around: data1=0xFFFFFFFF, data2=0xFFFFFFFF → result_o=0x00000001. data1=0x80000000, data2=2 → result_o=0.
- Non-MUL pass-through: start_i=1 with alu_ctrl_i=3'b000 and 3'b110 for 5 cycles → stall_o=0, busy_o=0, done_o=0, state stays IDLE.
- Flush mid-operation: MUL 7×9, assert flush_i at RUN cycle 10.
  - Next cycle: busy_o=0, stall_o=0.
  - done_o never pulses; result_o keeps its prior value.
  - A following MUL 2×4 yields 8.
- Async reset mid-RUN: assert rst_i between edges at RUN cycle 20 → stall_o, busy_o, result_o go to 0 before the next edge. After release, a MUL 6×7 gives 42.
- Back-to-back: MUL 10×10 held through DONE, then MUL 0x12345678×0x10 presented in the next cycle.
  - First done_o: result 100.
  - Second done_o exactly 34 cycles later: result 0x23456780.
  - Exactly one done_o pulse per MUL, no restart during DONE.
